// File: rtl/maxnet_seq_if.sv
// Handshake bundle between the Maxnet sequencer and the datapath/host it controls.
// The master modport is the host/datapath side and the slave modport is the sequencer.
interface maxnet_seq_if #(
    parameter int ITER_W = 5
);
    logic              start;
    logic              done;
    logic              mem_en;
    logic              sel_a;
    logic              iter_en;
    logic              result_signal;
    logic              ready;
    logic              busy;
    logic [ITER_W-1:0] iter_count;
    logic              timeout;

    modport master (
        output start, done,
        input  mem_en, sel_a, iter_en, result_signal, ready, busy, iter_count, timeout
    );

    modport slave (
        input  start, done,
        output mem_en, sel_a, iter_en, result_signal, ready, busy, iter_count, timeout
    );
endinterface

// File: rtl/maxnet_sequencer.sv
// Maxnet winner-take-all control: LOAD -> (ITER, CHECK)* -> RESULT.
// Define MAXNET_SEQ_TIMEOUT_EN to end a run after MAX_ITER iterations without convergence.
module maxnet_sequencer #(
    parameter int LOAD_CYCLES = 1,
    parameter int ITER_W      = 5,
    parameter int MAX_ITER    = 31
) (
    input  logic          clk,
    input  logic          rst,
    maxnet_seq_if.slave   bus
);
    localparam int LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LC_W-1:0]   LOAD_LAST = LC_W'(LOAD_CYCLES - 1);
    localparam logic [ITER_W-1:0] CNT_MAX   = '1;
    localparam logic [ITER_W-1:0] ITER_LIM  = ITER_W'(MAX_ITER);
`ifdef MAXNET_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, ITER, CHECK, RESULT} state_t;

    state_t            state_q, state_d;
    logic [LC_W-1:0]   load_cnt_q;
    logic [ITER_W-1:0] iter_cnt_q;
    logic              ready_q;
    logic              timeout_q;
    logic              limit_hit_q;
    logic              at_limit;
    logic              mem_en, sel_a, iter_en, result_strobe;

    assign at_limit = TIMEOUT_EN && (iter_cnt_q == ITER_LIM);

    always_comb begin
        state_d       = state_q;
        mem_en        = 1'b0;
        sel_a         = 1'b0;
        iter_en       = 1'b0;
        result_strobe = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                mem_en = 1'b1;
                if (load_cnt_q == LOAD_LAST) state_d = ITER;
            end
            ITER: begin
                sel_a   = 1'b1;
                iter_en = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                sel_a = 1'b1;
                // Convergence takes priority over the iteration limit.
                if (bus.done || at_limit) state_d = RESULT;
                else                      state_d = ITER;
            end
            RESULT: begin
                result_strobe = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            load_cnt_q  <= '0;
            iter_cnt_q  <= '0;
            ready_q     <= 1'b0;
            timeout_q   <= 1'b0;
            limit_hit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        load_cnt_q  <= '0;
                        iter_cnt_q  <= '0;
                        ready_q     <= 1'b0;
                        timeout_q   <= 1'b0;
                        limit_hit_q <= 1'b0;
                    end
                end
                LOAD:  load_cnt_q <= load_cnt_q + 1'b1;
                ITER: begin
                    if (iter_cnt_q != CNT_MAX) iter_cnt_q <= iter_cnt_q + 1'b1;
                end
                // Remember why the run ended so timeout can rise together with ready.
                CHECK: limit_hit_q <= !bus.done && at_limit;
                RESULT: begin
                    ready_q   <= 1'b1;
                    timeout_q <= limit_hit_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en        = mem_en;
    assign bus.sel_a         = sel_a;
    assign bus.iter_en       = iter_en;
    assign bus.result_signal = result_strobe;
    assign bus.busy          = (state_q != IDLE);
    assign bus.ready         = ready_q;
    assign bus.timeout       = timeout_q;
    assign bus.iter_count    = iter_cnt_q;
endmodule

// File: tb/tb_maxnet_sequencer.sv
// Randomized bench for maxnet_sequencer: two instances (default and LOAD_CYCLES=3/ITER_W=3/MAX_ITER=4)
// compared every cycle against a run-timeline reference model.
module tb_maxnet_sequencer;
`ifdef MAXNET_SEQ_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif
    localparam int NCYC = 6000;

    logic clk = 1'b0;
    logic rst, start_r, done_r;
    always #5 clk = ~clk;

    maxnet_seq_if #(.ITER_W(5)) if0 ();
    maxnet_seq_if #(.ITER_W(3)) if1 ();

    assign if0.start = start_r;
    assign if0.done  = done_r;
    assign if1.start = start_r;
    assign if1.done  = done_r;

    maxnet_sequencer #(.LOAD_CYCLES(1), .ITER_W(5), .MAX_ITER(31)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    maxnet_sequencer #(.LOAD_CYCLES(3), .ITER_W(3), .MAX_ITER(4))  dut1 (.clk(clk), .rst(rst), .bus(if1));

    int lc[2]   = '{1, 3};
    int wid[2]  = '{5, 3};
    int maxi[2] = '{31, 4};

    // Model state: a run is a timeline t = cycles since start was accepted.
    bit act[2];
    bit res[2];
    bit rdy[2];
    bit tmo[2];
    bit pend[2];
    int t[2];
    int k[2];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // 0 idle, 1 load, 2 iter, 3 check, 4 result
    function automatic int phase(input int i);
        if (!act[i]) return 0;
        if (res[i]) return 4;
        if (t[i] <= lc[i]) return 1;
        return (((t[i] - lc[i]) % 2) == 1) ? 2 : 3;
    endfunction

    function automatic int exp_cnt(input int i);
        int sat;
        sat = (1 << wid[i]) - 1;
        return (k[i] > sat) ? sat : k[i];
    endfunction

    task automatic model_step(input bit r, input bit s, input bit d);
        for (int i = 0; i < 2; i++) begin
            int p;
            p = phase(i);
            if (r) begin
                act[i] = 0; res[i] = 0; rdy[i] = 0; tmo[i] = 0; pend[i] = 0; t[i] = 0; k[i] = 0;
            end else begin
                case (p)
                    0: if (s) begin
                        act[i] = 1; res[i] = 0; rdy[i] = 0; tmo[i] = 0; pend[i] = 0; t[i] = 1; k[i] = 0;
                    end
                    1: t[i]++;
                    2: begin k[i]++; t[i]++; end
                    3: begin
                        if (d) begin res[i] = 1; pend[i] = 0; end
                        else if (TEN && exp_cnt(i) == maxi[i]) begin res[i] = 1; pend[i] = 1; end
                        else t[i]++;
                    end
                    default: begin act[i] = 0; res[i] = 0; rdy[i] = 1; tmo[i] = pend[i]; end
                endcase
            end
        end
    endtask

    task automatic check_inst(input int i, input logic me, input logic sa, input logic ie,
                              input logic rs, input logic rd, input logic bz,
                              input logic [31:0] ic, input logic to);
        int p;
        p = phase(i);
        check_eq($sformatf("u%0d.mem_en", i),        {31'd0, me}, int'(p == 1));
        check_eq($sformatf("u%0d.sel_a", i),         {31'd0, sa}, int'(p == 2 || p == 3));
        check_eq($sformatf("u%0d.iter_en", i),       {31'd0, ie}, int'(p == 2));
        check_eq($sformatf("u%0d.result_signal", i), {31'd0, rs}, int'(p == 4));
        check_eq($sformatf("u%0d.busy", i),          {31'd0, bz}, int'(p != 0));
        check_eq($sformatf("u%0d.ready", i),         {31'd0, rd}, int'(rdy[i]));
        check_eq($sformatf("u%0d.iter_count", i),    ic,          exp_cnt(i));
        check_eq($sformatf("u%0d.timeout", i),       {31'd0, to}, int'(tmo[i]));
    endtask

    initial begin
        int done_pct;
        rst = 1'b1; start_r = 1'b0; done_r = 1'b0;
        done_pct = 20;
        model_step(1'b1, 1'b0, 1'b0);
        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc > 0) begin
                check_inst(0, if0.mem_en, if0.sel_a, if0.iter_en, if0.result_signal,
                           if0.ready, if0.busy, {27'd0, if0.iter_count}, if0.timeout);
                check_inst(1, if1.mem_en, if1.sel_a, if1.iter_en, if1.result_signal,
                           if1.ready, if1.busy, {29'd0, if1.iter_count}, if1.timeout);
            end
            if (cyc % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0:       done_pct = 3;
                    1:       done_pct = 20;
                    default: done_pct = 60;
                endcase
            end
            rst     = (cyc < 2) || ($urandom_range(0, 249) == 0);
            start_r = ($urandom_range(0, 3) == 0);
            done_r  = ($urandom_range(0, 99) < done_pct);
            @(posedge clk);
            model_step(rst, start_r, done_r);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
